// File: rtl/inertial_pkg.sv
// Shared types and constants for the IMU front end: FSM states, SPI command words and
// default timing widths.
package inertial_pkg;

    localparam int unsigned DefInitWaitBits = 16;
    localparam int unsigned DefSclkDivBits  = 5;

    typedef enum logic [2:0] {
        StInitWait,
        StCfg,
        StIdle,
        StRdPl,
        StRdPh,
        StRdAl,
        StRdAh,
        StUpdate
    } imu_state_e;

    typedef enum logic {
        SpIdle,
        SpXfer
    } spi_state_e;

    localparam logic [15:0] CmdCfgInt   = 16'h0D02;
    localparam logic [15:0] CmdCfgAccel = 16'h1053;
    localparam logic [15:0] CmdCfgGyro  = 16'h1150;
    localparam logic [15:0] CmdCfgRound = 16'h1460;

    localparam logic [15:0] CmdRdPl = 16'hA200;
    localparam logic [15:0] CmdRdPh = 16'hA300;
    localparam logic [15:0] CmdRdAl = 16'hAC00;
    localparam logic [15:0] CmdRdAh = 16'hAD00;

    function automatic logic [15:0] cfg_cmd(input logic [1:0] idx);
        logic [15:0] cmd;
        case (idx)
            2'd0:    cmd = CmdCfgInt;
            2'd1:    cmd = CmdCfgAccel;
            2'd2:    cmd = CmdCfgGyro;
            default: cmd = CmdCfgRound;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/spi_mstr16.sv
// 16-bit SPI master, mode 3, MSB first. SCLK period is 2^SCLK_DIV_BITS clocks with a
// half-period of SCLK-high lead-in after SS_n falls and a half-period tail before it rises.
module spi_mstr16
    import inertial_pkg::*;
#(
    parameter int unsigned SCLK_DIV_BITS = DefSclkDivBits
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        done,
    output logic [15:0] rd_data
);

    localparam logic [SCLK_DIV_BITS-1:0] DivHalf = {1'b1, {(SCLK_DIV_BITS-1){1'b0}}};
    localparam logic [SCLK_DIV_BITS-1:0] DivRise = ~DivHalf;
    localparam logic [SCLK_DIV_BITS-1:0] DivFall = '1;
    localparam logic [SCLK_DIV_BITS-1:0] DivOne  = {{(SCLK_DIV_BITS-1){1'b0}}, 1'b1};

    spi_state_e               r_state;
    spi_state_e               w_state_d;
    logic [SCLK_DIV_BITS-1:0] r_div;
    logic [4:0]               r_bit_cnt;
    logic [15:0]              r_shft;
    logic                     r_smpl;
    logic                     r_ss_n;
    logic                     r_sclk;
    logic                     r_done;
    logic                     w_rise;
    logic                     w_fall;
    logic                     w_last;

    always_comb begin
        w_rise    = (r_state == SpXfer) && (r_div == DivRise);
        w_fall    = (r_state == SpXfer) && (r_div == DivFall);
        // The fall point after the 16th rise ends the frame instead of dropping SCLK.
        w_last    = w_fall && (r_bit_cnt == 5'd16);
        w_state_d = r_state;
        unique case (r_state)
            SpIdle:  if (wrt) w_state_d = SpXfer;
            SpXfer:  if (w_last) w_state_d = SpIdle;
            default: w_state_d = SpIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= SpIdle;
            r_div     <= '0;
            r_bit_cnt <= '0;
            r_shft    <= '0;
            r_smpl    <= 1'b0;
            r_ss_n    <= 1'b1;
            r_sclk    <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_done  <= w_last;
            if (r_state == SpIdle) begin
                if (wrt) begin
                    r_shft    <= cmd;
                    r_div     <= DivHalf;
                    r_bit_cnt <= '0;
                    r_ss_n    <= 1'b0;
                end
            end else begin
                r_div <= r_div + DivOne;
                if (w_rise) begin
                    r_sclk    <= 1'b1;
                    r_smpl    <= MISO;
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
                if (w_fall) begin
                    // First fall only opens the frame; MSB is already on MOSI.
                    if (r_bit_cnt != 5'd0) r_shft <= {r_shft[14:0], r_smpl};
                    if (w_last) r_ss_n <= 1'b1;
                    else        r_sclk <= 1'b0;
                end
            end
        end
    end

    assign SS_n    = r_ss_n;
    assign SCLK    = r_sclk;
    assign MOSI    = r_shft[15];
    assign done    = r_done;
    assign rd_data = r_shft;

endmodule

// File: rtl/inertial_interface.sv
// IMU front end: waits for power-up, configures the IMU, then on each data-ready reads
// pitch rate and Z acceleration and presents them with a one-cycle vld pulse.
module inertial_interface
    import inertial_pkg::*;
#(
    parameter int unsigned INIT_WAIT_BITS = DefInitWaitBits,
    parameter int unsigned SCLK_DIV_BITS  = DefSclkDivBits
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        vld,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ
);

    localparam logic [INIT_WAIT_BITS-1:0] TmrOne = {{(INIT_WAIT_BITS-1){1'b0}}, 1'b1};

    imu_state_e                r_state;
    imu_state_e                w_state_d;
    logic [INIT_WAIT_BITS-1:0] r_tmr;
    logic [1:0]                r_cfg_idx;
    logic                      r_wait;
    logic                      r_int_ff1;
    logic                      r_int_ff2;
    logic [7:0]                r_pl;
    logic [7:0]                r_ph;
    logic [7:0]                r_al;
    logic                      r_vld;
    logic [15:0]               r_ptch;
    logic [15:0]               r_az;
    logic                      w_wrt;
    logic [15:0]               w_cmd;
    logic                      w_done;
    logic [15:0]               w_rd_data;
    logic                      w_unused_rd_hi;

    spi_mstr16 #(
        .SCLK_DIV_BITS(SCLK_DIV_BITS)
    ) u_spi (
        .clk    (clk),
        .rst_n  (rst_n),
        .wrt    (w_wrt),
        .cmd    (w_cmd),
        .MISO   (MISO),
        .SS_n   (SS_n),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .done   (w_done),
        .rd_data(w_rd_data)
    );

    // Only the reply byte carries register data.
    assign w_unused_rd_hi = ^w_rd_data[15:8];

    always_comb begin
        w_state_d = r_state;
        w_wrt     = 1'b0;
        w_cmd     = CmdRdPl;
        unique case (r_state)
            StInitWait: if (r_tmr == '1) w_state_d = StCfg;
            StCfg: begin
                w_cmd = cfg_cmd(r_cfg_idx);
                w_wrt = !r_wait;
                if (w_done && r_cfg_idx == 2'd3) w_state_d = StIdle;
            end
            StIdle: if (r_int_ff2) w_state_d = StRdPl;
            StRdPl: begin
                w_cmd = CmdRdPl;
                w_wrt = !r_wait;
                if (w_done) w_state_d = StRdPh;
            end
            StRdPh: begin
                w_cmd = CmdRdPh;
                w_wrt = !r_wait;
                if (w_done) w_state_d = StRdAl;
            end
            StRdAl: begin
                w_cmd = CmdRdAl;
                w_wrt = !r_wait;
                if (w_done) w_state_d = StRdAh;
            end
            StRdAh: begin
                w_cmd = CmdRdAh;
                w_wrt = !r_wait;
                if (w_done) w_state_d = StUpdate;
            end
            StUpdate: w_state_d = StIdle;
            default:  w_state_d = StInitWait;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= StInitWait;
            r_tmr     <= '0;
            r_cfg_idx <= '0;
            r_wait    <= 1'b0;
            r_int_ff1 <= 1'b0;
            r_int_ff2 <= 1'b0;
            r_pl      <= '0;
            r_ph      <= '0;
            r_al      <= '0;
            r_vld     <= 1'b0;
            r_ptch    <= '0;
            r_az      <= '0;
        end else begin
            r_state   <= w_state_d;
            r_int_ff1 <= INT;
            r_int_ff2 <= r_int_ff1;
            if (r_state == StInitWait) r_tmr <= r_tmr + TmrOne;
            if (w_wrt)       r_wait <= 1'b1;
            else if (w_done) r_wait <= 1'b0;
            if (r_state == StCfg && w_done) r_cfg_idx <= r_cfg_idx + 2'd1;
            if (w_done) begin
                case (r_state)
                    StRdPl:  r_pl <= w_rd_data[7:0];
                    StRdPh:  r_ph <= w_rd_data[7:0];
                    StRdAl:  r_al <= w_rd_data[7:0];
                    default: ;
                endcase
            end
            // Loaded on the RD_AH done edge so the new pair and vld appear together in UPDATE.
            r_vld <= (r_state == StRdAh) && w_done;
            if (r_state == StRdAh && w_done) begin
                r_ptch <= {r_ph, r_pl};
                r_az   <= {w_rd_data[7:0], r_al};
            end
        end
    end

    assign vld     = r_vld;
    assign ptch_rt = r_ptch;
    assign AZ      = r_az;

endmodule

// File: tb/tb_inertial_interface.sv
// Directed bench for inertial_interface with a behavioural mode-3 IMU SPI slave.
module tb_inertial_interface;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        INT   = 1'b0;
    logic        MISO  = 1'b0;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        vld;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;

    always #5 clk = ~clk;

    inertial_interface #(
        .INIT_WAIT_BITS(6),
        .SCLK_DIV_BITS (5)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .INT    (INT),
        .MISO   (MISO),
        .SS_n   (SS_n),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .vld    (vld),
        .ptch_rt(ptch_rt),
        .AZ     (AZ)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // IMU register file seen by the slave model
    logic [7:0] m_pl = 8'h00;
    logic [7:0] m_ph = 8'h00;
    logic [7:0] m_al = 8'h00;
    logic [7:0] m_ah = 8'h00;

    function automatic logic [7:0] reg_read(input logic [7:0] addr);
        case (addr)
            8'hA2:   return m_pl;
            8'hA3:   return m_ph;
            8'hAC:   return m_al;
            8'hAD:   return m_ah;
            default: return 8'h00;
        endcase
    endfunction

    logic [15:0] fr_word[$];
    int          fr_bits[$];
    logic [15:0] rx_sr    = '0;
    int          rx_bits  = 0;
    logic        in_frame = 1'b0;
    logic [7:0]  rd_byte  = '0;

    always @(negedge SS_n) begin
        in_frame = 1'b1;
        rx_bits  = 0;
        MISO     = 1'b0;
    end

    always @(posedge SCLK) begin
        if (in_frame && SS_n === 1'b0) begin
            rx_sr = {rx_sr[14:0], MOSI};
            rx_bits++;
            if (rx_bits == 8) rd_byte = reg_read(rx_sr[7:0]);
        end
    end

    always @(negedge SCLK) begin
        if (in_frame && SS_n === 1'b0 && rx_bits >= 8 && rx_bits < 16) MISO = rd_byte[15-rx_bits];
    end

    always @(posedge SS_n) begin
        if (in_frame) begin
            in_frame = 1'b0;
            fr_word.push_back(rx_sr);
            fr_bits.push_back(rx_bits);
        end
    end

    // Output monitor
    int          cyc        = 0;
    bit          rst_seen   = 1'b1;
    int          vld_cnt    = 0;
    int          adj_vld    = 0;
    int          bad_change = 0;
    int          vld_cyc[$];
    logic [15:0] vld_p, vld_a;
    logic        prev_vld   = 1'b0;
    logic [15:0] prev_p, prev_a;

    always @(posedge clk) begin
        cyc++;
        rst_seen = !rst_n;
    end

    always @(negedge clk) begin
        if (vld === 1'b1) begin
            vld_cnt++;
            vld_p = ptch_rt;
            vld_a = AZ;
            vld_cyc.push_back(cyc);
            if (prev_vld) adj_vld++;
        end
        if (!rst_seen && vld !== 1'b1 && (ptch_rt !== prev_p || AZ !== prev_a)) bad_change++;
        prev_vld = (vld === 1'b1);
        prev_p   = ptch_rt;
        prev_a   = AZ;
    end

    task automatic wait_frames(input string tag, input int target, input int budget);
        int n = 0;
        while (fr_word.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(fr_word.size() >= target), 1);
    endtask

    task automatic wait_vld(input string tag, input int target, input int budget);
        int n = 0;
        while (vld_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(vld_cnt >= target), 1);
    endtask

    task automatic int_pulse(input int cycles);
        @(posedge clk);
        #1 INT = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 INT = 1'b0;
    endtask

    logic [15:0] cfg_exp[4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
    logic [15:0] rd_exp[4]  = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

    initial begin
        int n;
        int base_f;
        int base_v;
        int d1;
        int d2;
        int partial;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ss_n", SS_n, 1);
        check_eq("rst_sclk", SCLK, 1);
        check_eq("rst_mosi", MOSI, 0);
        check_eq("rst_vld", vld, 0);
        check_eq("rst_ptch", ptch_rt, 0);
        check_eq("rst_az", AZ, 0);

        @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        while (SS_n === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        // 64 clocks of power-up wait, one CFG cycle to issue wrt, SS_n low one clock later
        check_eq("init_quiet", 32'(n >= 65 && n <= 67), 1);

        wait_frames("cfg_frames", 4, 3000);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("cfg_word%0d", i), fr_word[i], cfg_exp[i]);
            check_eq($sformatf("cfg_bits%0d", i), fr_bits[i], 16);
        end
        repeat (600) @(negedge clk);
        check_eq("cfg_only4", fr_word.size(), 4);
        check_eq("cfg_no_vld", vld_cnt, 0);

        m_pl = 8'hC2;
        m_ph = 8'h10;
        m_al = 8'h00;
        m_ah = 8'h08;
        int_pulse(3);
        wait_vld("grp1_vld", 1, 3000);
        for (int i = 0; i < 4; i++) check_eq($sformatf("grp1_word%0d", i), fr_word[4+i], rd_exp[i]);
        check_eq("grp1_ptch", vld_p, 16'h10C2);
        check_eq("grp1_az", vld_a, 16'h0800);
        repeat (20) @(negedge clk);
        check_eq("grp1_hold", ptch_rt, 16'h10C2);
        check_eq("grp1_frames", fr_word.size(), 8);

        int_pulse(3);
        wait_frames("mid_pl_done", 9, 3000);
        m_ph = 8'hF3;
        check_eq("mid_hold", ptch_rt, 16'h10C2);
        wait_vld("mid_vld", 2, 3000);
        check_eq("mid_ptch", vld_p, 16'hF3C2);
        check_eq("mid_az", vld_a, 16'h0800);
        repeat (20) @(negedge clk);
        check_eq("mid_vld_cnt", vld_cnt, 2);
        check_eq("mid_out", ptch_rt, 16'hF3C2);

        base_v = vld_cnt;
        @(posedge clk);
        #1 INT = 1'b1;
        wait_vld("hold_vld", base_v + 3, 8000);
        INT = 1'b0;
        wait_vld("hold_tail", base_v + 4, 3000);
        d1 = vld_cyc[base_v+1] - vld_cyc[base_v];
        d2 = vld_cyc[base_v+2] - vld_cyc[base_v+1];
        check_eq("hold_space", 32'(d1 >= 4 * 528 + 2 && d1 <= 4 * 560 + 2), 1);
        check_eq("hold_even", d2, d1);
        repeat (2500) @(negedge clk);
        check_eq("hold_stop", vld_cnt, base_v + 4);

        base_f = fr_word.size();
        int_pulse(3);
        wait_frames("rst_pre", base_f + 2, 3000);
        n = 0;
        while (SS_n !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (100) @(negedge clk);
        base_v = vld_cnt;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_eq("mrst_ss_n", SS_n, 1);
        check_eq("mrst_sclk", SCLK, 1);
        check_eq("mrst_vld", vld, 0);
        check_eq("mrst_ptch", ptch_rt, 0);
        check_eq("mrst_az", AZ, 0);
        check_eq("mrst_partial", 32'(fr_word.size() == base_f + 3 && fr_bits[base_f+2] < 16), 1);
        wait_frames("mrst_cfg", base_f + 7, 3500);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("mrst_cfg%0d", i), fr_word[base_f+3+i], cfg_exp[i]);
        repeat (300) @(negedge clk);
        check_eq("mrst_no_vld", vld_cnt, base_v);
        check_eq("mrst_frames", fr_word.size(), base_f + 7);

        base_f = fr_word.size();
        base_v = vld_cnt;
        @(negedge clk);
        #1 INT = 1'b1;
        #2 INT = 1'b0;
        repeat (100) @(negedge clk);
        check_eq("glitch_ignored", fr_word.size(), base_f);
        @(negedge clk);
        #4 INT = 1'b1;
        #2 INT = 1'b0;
        repeat (2500) @(negedge clk);
        check_eq("glitch_frames", fr_word.size(), base_f + 4);
        check_eq("glitch_vld", vld_cnt, base_v + 1);
        check_eq("glitch_ptch", ptch_rt, 16'hF3C2);

        partial = 0;
        foreach (fr_bits[i]) if (fr_bits[i] != 16) partial++;
        check_eq("partial_frames", partial, 1);
        check_eq("adjacent_vld", adj_vld, 0);
        check_eq("out_changes", bad_change, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/inertial_interface.md
Name: inertial_interface

Overview:
- Producer side of the pitch integrator's input interface.
- Configures the 6-axis IMU over SPI after reset, then services each IMU data-ready interrupt. On each interrupt it reads pitch rate and Z acceleration.
- Presents ptch_rt/AZ with a one-cycle vld pulse, exactly the vld/ptch_rt/AZ contract the downstream pitch integrator consumes.
- Sits between the IMU pins and the integrator.

Parameters:
- INIT_WAIT_BITS, 16, width of the post-reset IMU power-up timer; wait is 2^INIT_WAIT_BITS clocks. Benches may shrink it, e.g. to 6.
- SCLK_DIV_BITS, 5, SCLK period is 2^SCLK_DIV_BITS clocks (default 32).

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset: synchronous, active-low.
- INT  in  1  IMU data-ready, asynchronous, active-high.
- MISO  in  1  SPI data from IMU.
- SS_n  out  1  SPI slave select, active-low.
- SCLK  out  1  SPI clock, mode 3 (idles high).
- MOSI  out  1  SPI data to IMU.
- vld  out  1  one-clock pulse: new ptch_rt/AZ pair valid.
- ptch_rt  out  16  signed raw pitch rate {high byte, low byte}.
- AZ  out  16  signed raw Z acceleration {high byte, low byte}.

Behaviour:
- Reset values while rst_n is low at a clk edge:
  - vld=0, ptch_rt=0, AZ=0.
  - SS_n=1, SCLK=1, MOSI=0.
  - FSM in INIT_WAIT, timer=0, INT sync flops=0.
- INT synchronisation: passed through a double flop before use; 2-clock latency.
- SPI transaction, performed by the sub-module:
  - A 16-bit frame, MSB first.
  - MOSI changes on SCLK fall; MISO is sampled on SCLK rise.
  - SS_n falls one clk after wrt and rises half a SCLK period after the 16th rising edge.
  - done pulses for one clk in the cycle SS_n returns high.
  - rd_data[7:0] holds the IMU reply byte.
  - wrt while busy is ignored.
- FSM states:
  - INIT_WAIT: counts to all-ones, then goes to CFG.
  - CFG: issues four writes in order, each waiting for done: 0x0D02 (INT on data-ready), 0x1053 (accel 208 Hz), 0x1150 (gyro 208 Hz), 0x1460 (rounding). Then goes to IDLE.
  - IDLE: on synced INT high, goes to RD_PL.
  - RD_PL / RD_PH / RD_AL / RD_AH: reads with cmd 0xA200, 0xA300, 0xAC00, 0xAD00. Each captures rd_data[7:0] into a holding register on done.
  - UPDATE: the cycle after the RD_AH done, ptch_rt and AZ load atomically and vld=1 for exactly one clk. Then back to IDLE.
- Output stability: outputs change only in UPDATE and hold otherwise. A partially read set never reaches the outputs.
- INT level handling:
  - INT is level-checked only in IDLE; INT activity during reads is ignored.
  - If INT is still high on return to IDLE, a new read starts on the next clk.
  - Minimum spacing between vld pulses = 4 frames + 2 clks.
- Reset mid-transaction: next edge forces SS_n=1, SCLK=1 and INIT_WAIT; the full config is redone. No vld pulse.
- Widths: no arithmetic on data (pure byte concatenation). The timer wraps only via the INIT_WAIT exit.

Decomposition:
- Package inertial_pkg holds:
  - state enum (INIT_WAIT, CFG, IDLE, RD_PL, RD_PH, RD_AL, RD_AH, UPDATE);
  - config command constants and read command constants;
  - default parameter values.
- One sub-module, spi_mstr16 (ports clk, rst_n, wrt, cmd[15:0], MISO, SS_n, SCLK, MOSI, done, rd_data[15:0]). It holds the SCLK divider, shift register and bit counter.
- inertial_interface holds the FSM, timer, config index, INT synchroniser and holding registers.

Test Plan:
- Reset then release with INIT_WAIT_BITS=6 and an IMU SPI slave model:
  - no SS_n activity for 64 clks;
  - then exactly four frames with MOSI words 0x0D02, 0x1053, 0x1150, 0x1460;
  - vld stays 0.
- Model returns pitch 0x10C2 (L=0xC2, H=0x10) and AZ 0x0800; pulse INT:
  - frames 0xA200, 0xA300, 0xAC00, 0xAD00;
  - vld high for 1 clk with ptch_rt=0x10C2, AZ=0x0800.
- Model data changes to pitch 0xF3C2 mid-read (between RD_PL and RD_PH):
  - ptch_rt stays 0x10C2 until the UPDATE cycle, then shows the captured bytes;
  - vld count +1 only.
- INT held high continuously:
  - back-to-back read groups;
  - vld pulses spaced 4*(16*32+~32)+2 clks; never two pulses in adjacent cycles.
- rst_n low for 1 clk during the RD_AL frame:
  - SS_n=1 and SCLK=1 next clk, vld=0, ptch_rt=AZ=0;
  - config sequence replays in full.
- INT glitch shorter than 1 clk, asynchronous to clk: either ignored or a single clean read group. No SS_n toggling outside full 16-bit frames.
